punc_ctrl_mc: RTL

PUNC_CTRL_MC -- requirements
Module: punc_ctrl_mc

---
 rtl/punc_ctrl_mc.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/punc_ctrl_mc.sv
// Multi-cycle control unit for a 16-bit load/store CPU: fetch/decode/execute
// sequencing, memory handshake with ack timeout, fault capture and retired count.
module punc_ctrl_mc #(
   parameter int ACK_TIMEOUT = 15,
   parameter int RET_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ir,
   input  logic             mem_ack,
   input  logic             resume,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [1:0]       mem_addr_sel,
   output logic             ir_ld,
   output logic             pc_clr,
   output logic             pc_up,
   output logic             pc_ld,
   output logic             jmp_base,
   output logic             rf_wr_en,
   output logic [2:0]       rf_wr_addr,
   output logic [2:0]       rf_r_addr_0,
   output logic [2:0]       rf_r_addr_1,
   output logic [1:0]       rf_w_data_sel,
   output logic [1:0]       alu_sel,
   output logic             add_const,
   output logic             cc_en,
   output logic [2:0]       nzp,
   output logic [1:0]       sext_sel,
   output logic [2:0]       state_o,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_EXEC2  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [7:0] TMO = ACK_TIMEOUT[7:0];

   state_t           state_q, state_d, ack_next_s;
   logic [7:0]       wait_q, wait_d;
   logic [1:0]       fault_q, fault_d;
   logic [RET_W-1:0] retired_q, retired_d;
   logic [3:0]       op_s;
   logic             load_s, retire_s;
   logic             unused_ir_s;

   assign op_s        = ir[15:12];
   assign unused_ir_s = ^ir[4:3];

   // Next-state, fault and per-state strobe decode.
   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      ack_next_s    = S_FETCH;
      load_s        = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      mem_addr_sel  = 2'b00;
      ir_ld         = 1'b0;
      pc_clr        = 1'b0;
      pc_up         = 1'b0;
      pc_ld         = 1'b0;
      jmp_base      = 1'b0;
      rf_wr_en      = 1'b0;
      rf_wr_addr    = 3'd0;
      rf_r_addr_0   = 3'd0;
      rf_r_addr_1   = 3'd0;
      rf_w_data_sel = 2'b00;
      alu_sel       = 2'b00;
      add_const     = 1'b0;
      cc_en         = 1'b0;
      nzp           = 3'd0;
      sext_sel      = 2'b00;
      case (state_q)
         S_INIT: begin
            pc_clr  = 1'b1;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd     = 1'b1;
            ack_next_s = S_DECODE;
         end
         S_DECODE: begin
            pc_up = 1'b1;
            if (op_s == 4'b1111) begin
               state_d = S_HALT;
               fault_d = 2'b00;
            end else if ((op_s == 4'b1000) || (op_s == 4'b1101)) begin
               state_d = S_HALT;
               fault_d = 2'b01;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_s)
               4'b0001, 4'b0101: begin
                  alu_sel     = (op_s == 4'b0001) ? 2'b01 : 2'b10;
                  add_const   = ir[5];
                  rf_wr_en    = 1'b1;
                  rf_wr_addr  = ir[11:9];
                  rf_r_addr_0 = ir[8:6];
                  rf_r_addr_1 = ir[2:0];
                  cc_en       = 1'b1;
                  state_d     = S_FETCH;
               end
               4'b1001: begin
                  alu_sel     = 2'b11;
                  rf_r_addr_0 = ir[8:6];
                  rf_wr_en    = 1'b1;
                  rf_wr_addr  = ir[11:9];
                  cc_en       = 1'b1;
                  state_d     = S_FETCH;
               end
               4'b0000: begin
                  nzp      = ir[11:9];
                  sext_sel = 2'b01;
                  state_d  = S_FETCH;
               end
               4'b1100: begin
                  pc_ld       = 1'b1;
                  jmp_base    = 1'b1;
                  rf_r_addr_0 = ir[8:6];
                  state_d     = S_FETCH;
               end
               4'b0100: begin
                  pc_ld         = 1'b1;
                  jmp_base      = ~ir[11];
                  sext_sel      = 2'b11;
                  rf_wr_en      = 1'b1;
                  rf_wr_addr    = 3'd7;
                  rf_w_data_sel = 2'b01;
                  rf_r_addr_0   = ir[8:6];
                  state_d       = S_FETCH;
               end
               4'b1110: begin
                  sext_sel      = 2'b01;
                  rf_w_data_sel = 2'b11;
                  rf_wr_en      = 1'b1;
                  rf_wr_addr    = ir[11:9];
                  cc_en         = 1'b1;
                  state_d       = S_FETCH;
               end
               4'b0010: begin
                  mem_rd       = 1'b1;
                  mem_addr_sel = 2'b01;
                  load_s       = 1'b1;
               end
               4'b0110: begin
                  mem_rd       = 1'b1;
                  mem_addr_sel = 2'b10;
                  add_const    = 1'b1;
                  alu_sel      = 2'b01;
                  sext_sel     = 2'b10;
                  rf_r_addr_0  = ir[8:6];
                  load_s       = 1'b1;
               end
               4'b0011: begin
                  mem_wr       = 1'b1;
                  mem_addr_sel = 2'b01;
                  rf_r_addr_0  = ir[11:9];
               end
               4'b0111: begin
                  mem_wr       = 1'b1;
                  mem_addr_sel = 2'b10;
                  add_const    = 1'b1;
                  alu_sel      = 2'b01;
                  sext_sel     = 2'b10;
                  rf_r_addr_0  = ir[11:9];
                  rf_r_addr_1  = ir[8:6];
               end
               4'b1010, 4'b1011: begin
                  mem_rd       = 1'b1;
                  mem_addr_sel = 2'b01;
                  ack_next_s   = S_EXEC2;
               end
               default: begin
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC2: begin
            mem_addr_sel = 2'b11;
            if (op_s == 4'b1010) begin
               mem_rd = 1'b1;
               load_s = 1'b1;
            end else begin
               mem_wr      = 1'b1;
               rf_r_addr_0 = ir[11:9];
            end
         end
         S_HALT: begin
            if ((fault_q == 2'b00) && resume) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_HALT;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase

      // Memory handshake: ack wins over a timeout landing in the same cycle.
      if (mem_rd || mem_wr) begin
         if (mem_ack) begin
            state_d = ack_next_s;
            if (state_q == S_FETCH) begin
               ir_ld = 1'b1;
            end else if (load_s) begin
               rf_wr_en      = 1'b1;
               rf_wr_addr    = ir[11:9];
               rf_w_data_sel = 2'b10;
               cc_en         = 1'b1;
            end else begin
               ir_ld = 1'b0;
            end
         end else if (wait_q == TMO) begin
            state_d = S_HALT;
            fault_d = 2'b10;
         end else begin
            state_d = state_q;
         end
      end else begin
         load_s = 1'b0;
      end
   end

   // Wait counter and retired-instruction count.
   always_comb begin
      retire_s  = ((state_q == S_EXEC) || (state_q == S_EXEC2)) && (state_d == S_FETCH);
      retired_d = retired_q + {{(RET_W-1){1'b0}}, retire_s};
      if (state_d != state_q) begin
         wait_d = 8'd0;
      end else if ((mem_rd || mem_wr) && !mem_ack) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_INIT;
         wait_q    <= 8'd0;
         fault_q   <= 2'b00;
         retired_q <= {RET_W{1'b0}};
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   assign state_o = state_q;
   assign halted  = (state_q == S_HALT);
   assign fault   = fault_q;
   assign retired = retired_q;

endmodule
